quick_spi_master: RTL and testbench

- Second-generation SPI master for the QuickSPI family.
- Runs full-duplex transfers of run-time-selectable length (1..DATA_WIDTH bits).
- Mode (CPOL/CPHA), bit order and SCLK divider are selected per transaction.
- Drives up to NUM_SLAVES chip selects. Sits between a register/host front-end and the off-chip SPI pins.

---
 rtl/quick_spi_pkg.sv | 27 ++
 rtl/quick_spi_clkgen.sv | 63 ++++++
 rtl/quick_spi_master.sv | 225 ++++++++++++++++++++++
 tb/tb_quick_spi_master.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quick_spi_pkg.sv
// -----------------------------------------------------------------------------
// quick_spi_pkg
// Shared types and helpers for the QuickSPI master family.
//   state_t     : transfer sequencer states
//   LSB_FIRST / MSB_FIRST : encodings of the lsb_first control bit
//   eff_len()   : maps the len field onto the number of bits actually moved
// -----------------------------------------------------------------------------
package quick_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic LSB_FIRST = 1'b1;
    localparam logic MSB_FIRST = 1'b0;

    // A len of 0 selects the full word; out-of-range values are clamped so the
    // bit counter can never run past the shift registers.
    function automatic int eff_len(input int len, input int max_len);
        return (len == 0 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/quick_spi_clkgen.sv
// -----------------------------------------------------------------------------
// quick_spi_clkgen
// SCLK divider and edge-strobe generator.
//   clk, reset : system clock, synchronous active-high reset
//   load       : capture clk_div/cpol and restart the divider (transfer start)
//   cpol       : idle level of sclk for the transfer being loaded
//   clk_div    : half-period of sclk is clk_div+1 clk cycles
//   run        : divider counts while high
//   toggle     : a divider tick also flips sclk while high
//   sclk       : serial clock
//   tick       : divider expired this cycle
//   lead/trail : this tick produces the leading / trailing sclk edge
// -----------------------------------------------------------------------------
module quick_spi_clkgen #(
    parameter int   DIV_WIDTH        = 8,
    parameter logic SCLK_RESET_VALUE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 cpol,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic                 run,
    input  logic                 toggle,
    output logic                 sclk,
    output logic                 tick,
    output logic                 lead,
    output logic                 trail
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 cpol_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            div_cnt <= '0;
            cpol_q  <= SCLK_RESET_VALUE;
            sclk    <= SCLK_RESET_VALUE;
        end else if (load) begin
            div_q   <= clk_div;
            div_cnt <= clk_div;
            cpol_q  <= cpol;
            sclk    <= cpol;
        end else if (run) begin
            if (div_cnt == '0) begin
                div_cnt <= div_q;
            end else begin
                div_cnt <= div_cnt - DIV_WIDTH'(1);
            end
            if (tick && toggle) begin
                sclk <= ~sclk;
            end
        end
    end

    assign tick  = run && (div_cnt == '0);
    // sclk sitting at its idle level means the next edge is the leading one.
    assign lead  = tick && toggle && (sclk == cpol_q);
    assign trail = tick && toggle && (sclk != cpol_q);

endmodule

// File: rtl/quick_spi_master.sv
// -----------------------------------------------------------------------------
// quick_spi_master
// Full-duplex SPI master, 1..DATA_WIDTH bits per transfer, per-transfer mode,
// bit order and SCLK divider, NUM_SLAVES active-low selects.
//   clk, reset   : system clock, synchronous active-high reset
//   start        : transfer request, honoured only while busy=0
//   slave        : select line index; out-of-range requests pulse err
//   cpol, cpha   : SPI mode for the transfer
//   lsb_first    : bit order
//   len          : bits to move, 0 = DATA_WIDTH
//   clk_div      : sclk half-period = clk_div+1 clk cycles
//   tx_data      : outgoing word, right-justified
//   busy         : acceptance through end of the inter-transfer gap
//   done, err    : single-cycle status pulses
//   rx_data      : received word, right-justified, held until the next done
//   mosi, miso, sclk, ss_n : SPI pins
// -----------------------------------------------------------------------------
module quick_spi_master
    import quick_spi_pkg::*;
#(
    parameter int   NUM_SLAVES       = 1,
    parameter int   DATA_WIDTH       = 32,
    parameter int   DIV_WIDTH        = 8,
    parameter int   SS_GAP_CYCLES    = 2,
    parameter logic MOSI_IDLE_VALUE  = 1'b0,
    parameter logic SCLK_RESET_VALUE = 1'b0,
    localparam int  SEL_W            = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int  LEN_W            = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SEL_W-1:0]      slave,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [LEN_W-1:0]      len,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  sclk,
    output logic [NUM_SLAVES-1:0] ss_n
);

    localparam int GAP_W = $clog2(SS_GAP_CYCLES + 1);

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic                  reject;
    logic                  finish;
    logic                  run;
    logic                  toggle;
    logic                  tick;
    logic                  lead;
    logic                  trail;
    logic                  cpha_q;
    logic                  lsb_q;
    logic [LEN_W-1:0]      len_eff;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      bit_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [DATA_WIDTH-1:0] tx_aligned;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;

    // The bit about to leave sits at bit 0 (LSB-first) or the top bit.
    function automatic logic next_bit(input logic [DATA_WIDTH-1:0] sr, input logic lsb);
        return (lsb == LSB_FIRST) ? sr[0] : sr[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] sr,
                                                        input logic lsb);
        return (lsb == LSB_FIRST) ? (sr >> 1) : (sr << 1);
    endfunction

    // LSB-first fills from the top so the first bit ends up lowest once the
    // word is right-justified at the end of the transfer.
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr,
                                                       input logic lsb, input logic din);
        if (lsb == LSB_FIRST) begin
            return (sr >> 1) | (DATA_WIDTH'(din) << (DATA_WIDTH - 1));
        end
        return (sr << 1) | DATA_WIDTH'(din);
    endfunction

    assign len_eff = LEN_W'(eff_len(int'(len), DATA_WIDTH));
    // MSB-first words are left-justified so the first bit is always the top bit.
    assign tx_aligned = (lsb_first == MSB_FIRST) ? (tx_data << (DATA_WIDTH - int'(len_eff)))
                                                 : tx_data;

    assign busy   = (state != IDLE);
    assign run    = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    // The tick that ends SETUP is the first edge; the tick after the final
    // trailing edge only closes the last half-period and moves to HOLD.
    assign toggle = (state == SETUP) || ((state == SHIFT) && (bit_cnt != '0));

    quick_spi_clkgen #(
        .DIV_WIDTH        (DIV_WIDTH),
        .SCLK_RESET_VALUE (SCLK_RESET_VALUE)
    ) u_clkgen (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .cpol    (cpol),
        .clk_div (clk_div),
        .run     (run),
        .toggle  (toggle),
        .sclk    (sclk),
        .tick    (tick),
        .lead    (lead),
        .trail   (trail)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (int'(slave) < NUM_SLAVES) begin
                        accept     = 1'b1;
                        state_next = SETUP;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SETUP: if (tick) state_next = SHIFT;
            SHIFT: if (tick && (bit_cnt == '0)) state_next = HOLD;
            HOLD: begin
                if (tick) begin
                    finish     = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: if (gap_cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values regardless of statement order in the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift registers are reset along with the control state
            // so an aborted transfer can never leak stale bits into rx_data.
            done    <= 1'b0;
            err     <= 1'b0;
            rx_data <= '0;
            mosi    <= MOSI_IDLE_VALUE;
            ss_n    <= '1;
            cpha_q  <= 1'b0;
            lsb_q   <= MSB_FIRST;
            len_q   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else begin
            done <= 1'b0;
            err  <= reject;

            if (accept) begin
                cpha_q  <= cpha;
                lsb_q   <= lsb_first;
                len_q   <= len_eff;
                bit_cnt <= len_eff;
                tx_sr   <= tx_aligned;
                rx_sr   <= '0;
                ss_n    <= ~(NUM_SLAVES'(1) << slave);
                // With cpha=0 the slave samples on the first edge, so the first
                // bit must already be on the wire during SETUP.
                mosi    <= cpha ? MOSI_IDLE_VALUE : next_bit(tx_aligned, lsb_first);
            end

            if (lead) begin
                if (cpha_q) begin
                    mosi  <= next_bit(tx_sr, lsb_q);
                    tx_sr <= shift_out(tx_sr, lsb_q);
                end else begin
                    rx_sr <= shift_in(rx_sr, lsb_q, miso);
                end
            end

            if (trail) begin
                bit_cnt <= bit_cnt - LEN_W'(1);
                if (cpha_q) begin
                    rx_sr <= shift_in(rx_sr, lsb_q, miso);
                end else if (bit_cnt != LEN_W'(1)) begin
                    mosi  <= next_bit(shift_out(tx_sr, lsb_q), lsb_q);
                    tx_sr <= shift_out(tx_sr, lsb_q);
                end
            end

            if (finish) begin
                ss_n    <= '1;
                mosi    <= MOSI_IDLE_VALUE;
                done    <= 1'b1;
                rx_data <= (lsb_q == LSB_FIRST) ? (rx_sr >> (DATA_WIDTH - int'(len_q))) : rx_sr;
                gap_cnt <= GAP_W'(SS_GAP_CYCLES - 1);
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_quick_spi_master.sv
// -----------------------------------------------------------------------------
// tb_quick_spi_master
// Directed, table-driven bench for quick_spi_master (NUM_SLAVES=3, 32-bit).
// Cycle numbering: the cycle in which start is sampled is cycle 0; values are
// read 1 time unit after each rising clk edge.
// -----------------------------------------------------------------------------
module tb_quick_spi_master;

    localparam int NUM_SLAVES    = 3;
    localparam int DATA_WIDTH    = 32;
    localparam int DIV_WIDTH     = 8;
    localparam int SS_GAP_CYCLES = 2;
    localparam int SEL_W         = 2;
    localparam int LEN_W         = 6;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [SEL_W-1:0]      slave;
    logic                  cpol;
    logic                  cpha;
    logic                  lsb_first;
    logic [LEN_W-1:0]      len;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  mosi;
    logic                  miso;
    logic                  sclk;
    logic [NUM_SLAVES-1:0] ss_n;

    logic loop_en;
    logic miso_const;
    assign miso = loop_en ? mosi : miso_const;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    quick_spi_master #(
        .NUM_SLAVES       (NUM_SLAVES),
        .DATA_WIDTH       (DATA_WIDTH),
        .DIV_WIDTH        (DIV_WIDTH),
        .SS_GAP_CYCLES    (SS_GAP_CYCLES),
        .MOSI_IDLE_VALUE  (1'b0),
        .SCLK_RESET_VALUE (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .slave     (slave),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .len       (len),
        .clk_div   (clk_div),
        .tx_data   (tx_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rx_data   (rx_data),
        .mosi      (mosi),
        .miso      (miso),
        .sclk      (sclk),
        .ss_n      (ss_n)
    );

    typedef struct {
        logic [SEL_W-1:0]      slave;
        logic                  cpol;
        logic                  cpha;
        logic                  lsb;
        logic [LEN_W-1:0]      len;
        logic [DIV_WIDTH-1:0]  div;
        logic [DATA_WIDTH-1:0] tx;
        logic                  loop;
        logic                  miso_c;
        logic [DATA_WIDTH-1:0] exp_rx;
        logic [DATA_WIDTH-1:0] exp_mosi;   // bits seen on mosi, in word order
        int                    exp_done;   // cycle of the done pulse
        int                    exp_edges;  // sclk transitions
        logic [NUM_SLAVES-1:0] exp_ss;     // ss_n while selected
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        #1;
    endtask

    // Launches one transfer and watches it until busy drops (bounded).
    task automatic run_xfer(input vec_t v, output int done_cyc, output int edges,
                            output int idle_cyc, output int n_done,
                            output logic [DATA_WIDTH-1:0] mosi_word,
                            output logic [NUM_SLAVES-1:0] ss_at1);
        logic prev;
        logic samp_lvl;
        int   nbits;
        done_cyc  = -1;
        edges     = 0;
        idle_cyc  = -1;
        n_done    = 0;
        mosi_word = '0;
        nbits     = 0;
        // Sampling edge is rising for modes 0 and 3, falling for modes 1 and 2.
        samp_lvl  = (v.cpol == v.cpha);
        slave      = v.slave;
        cpol       = v.cpol;
        cpha       = v.cpha;
        lsb_first  = v.lsb;
        len        = v.len;
        clk_div    = v.div;
        tx_data    = v.tx;
        loop_en    = v.loop;
        miso_const = v.miso_c;
        start      = 1'b1;
        tick_cycle();
        start  = 1'b0;
        ss_at1 = ss_n;
        prev   = sclk;
        for (int cyc = 1; cyc < 600; cyc++) begin
            if (sclk !== prev) begin
                edges++;
                if (sclk === samp_lvl) begin
                    if (v.lsb) mosi_word[nbits[4:0]] = mosi;
                    else       mosi_word = {mosi_word[DATA_WIDTH-2:0], mosi};
                    nbits++;
                end
            end
            prev = sclk;
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            if (busy === 1'b0) begin
                idle_cyc = cyc;
                break;
            end
            tick_cycle();
        end
    endtask

    initial begin
        int                    done_cyc, edges, idle_cyc, n_done;
        logic [DATA_WIDTH-1:0] mosi_word;
        logic [NUM_SLAVES-1:0] ss_at1;

        //              slave cpol  cpha  lsb   len    div   tx              loop  miso  exp_rx          exp_mosi        done edges ss
        vecs[0] = '{2'd0, 1'b0, 1'b0, 1'b0, 6'd8,  8'd0, 32'h0000_00A5, 1'b1, 1'b0, 32'h0000_00A5, 32'h0000_00A5, 19,  16, 3'b110};
        vecs[1] = '{2'd2, 1'b1, 1'b1, 1'b1, 6'd12, 8'd3, 32'h0000_05C3, 1'b0, 1'b1, 32'h0000_0FFF, 32'h0000_05C3, 105, 24, 3'b011};
        vecs[2] = '{2'd0, 1'b0, 1'b0, 1'b0, 6'd0,  8'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 67,  64, 3'b110};
        vecs[3] = '{2'd0, 1'b0, 1'b1, 1'b0, 6'd0,  8'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 67,  64, 3'b110};
        vecs[4] = '{2'd0, 1'b1, 1'b0, 1'b0, 6'd0,  8'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 67,  64, 3'b110};
        vecs[5] = '{2'd0, 1'b1, 1'b1, 1'b0, 6'd0,  8'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 67,  64, 3'b110};
        vecs[6] = '{2'd1, 1'b0, 1'b1, 1'b1, 6'd5,  8'd1, 32'hFFFF_FF13, 1'b1, 1'b0, 32'h0000_0013, 32'h0000_0013, 25,  10, 3'b101};
        vecs[7] = '{2'd0, 1'b1, 1'b0, 1'b0, 6'd4,  8'd2, 32'h0000_0ABC, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_000C, 31,  8,  3'b110};
        vecs[8] = '{2'd0, 1'b0, 1'b0, 1'b0, 6'd1,  8'd0, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0001, 5,   2,  3'b110};

        reset      = 1'b1;
        start      = 1'b0;
        slave      = '0;
        cpol       = 1'b0;
        cpha       = 1'b0;
        lsb_first  = 1'b0;
        len        = '0;
        clk_div    = '0;
        tx_data    = '0;
        loop_en    = 1'b1;
        miso_const = 1'b0;
        repeat (3) tick_cycle();
        reset = 1'b0;

        // ---- reset state ----
        check("reset busy",    64'(busy),    64'(0));
        check("reset done",    64'(done),    64'(0));
        check("reset err",     64'(err),     64'(0));
        check("reset rx_data", 64'(rx_data), 64'(0));
        check("reset mosi",    64'(mosi),    64'(0));
        check("reset sclk",    64'(sclk),    64'(0));
        check("reset ss_n",    64'(ss_n),    64'(3'b111));

        // ---- table-driven transfers ----
        for (int i = 0; i < 9; i++) begin
            run_xfer(vecs[i], done_cyc, edges, idle_cyc, n_done, mosi_word, ss_at1);
            check($sformatf("v%0d rx_data", i),   64'(rx_data),   64'(vecs[i].exp_rx));
            check($sformatf("v%0d mosi bits", i), 64'(mosi_word), 64'(vecs[i].exp_mosi));
            check($sformatf("v%0d done cycle", i), 64'(done_cyc), 64'(vecs[i].exp_done));
            check($sformatf("v%0d done count", i), 64'(n_done),   64'(1));
            check($sformatf("v%0d sclk edges", i), 64'(edges),    64'(vecs[i].exp_edges));
            check($sformatf("v%0d idle cycle", i), 64'(idle_cyc), 64'(vecs[i].exp_done + SS_GAP_CYCLES));
            check($sformatf("v%0d ss_n active", i), 64'(ss_at1),  64'(vecs[i].exp_ss));
            check($sformatf("v%0d ss_n idle", i),  64'(ss_n),     64'(3'b111));
            check($sformatf("v%0d sclk idle", i),  64'(sclk),     64'(vecs[i].cpol));
            check($sformatf("v%0d mosi idle", i),  64'(mosi),     64'(0));
            tick_cycle();
        end

        // ---- invalid slave: err pulse only ----
        begin
            int n_err;
            slave = 2'd3;
            start = 1'b1;
            tick_cycle();
            start = 1'b0;
            check("bad slave err",  64'(err),  64'(1));
            check("bad slave busy", 64'(busy), 64'(0));
            check("bad slave ss_n", 64'(ss_n), 64'(3'b111));
            n_err = 0;
            for (int c = 0; c < 5; c++) begin
                tick_cycle();
                if (err === 1'b1 || busy !== 1'b0 || ss_n !== 3'b111) n_err++;
            end
            check("bad slave aftermath", 64'(n_err), 64'(0));
        end

        // ---- back-to-back with start held high ----
        begin
            logic [15:0] w;
            int   nb, ndone, hi_run, gap_hi, seg;
            logic prev_s, prev_ss0;
            slave      = 2'd0;
            cpol       = 1'b0;
            cpha       = 1'b0;
            lsb_first  = 1'b0;
            len        = 6'd8;
            clk_div    = 8'd0;
            tx_data    = 32'h0000_00A5;
            loop_en    = 1'b1;
            start      = 1'b1;
            tick_cycle();
            w = '0; nb = 0; ndone = 0; hi_run = 0; gap_hi = -1; seg = 0;
            prev_s   = sclk;
            prev_ss0 = 1'b1;
            for (int cyc = 1; cyc < 200; cyc++) begin
                if (cyc == 5) tx_data = 32'h0000_003C;
                if (sclk !== prev_s && sclk === 1'b1) begin
                    w = {w[14:0], mosi};
                    nb++;
                end
                prev_s = sclk;
                if (done === 1'b1) ndone++;
                if (ss_n[0] === 1'b0) begin
                    if (prev_ss0) begin
                        seg++;
                        if (seg == 2) begin
                            gap_hi = hi_run;
                            start  = 1'b0;
                        end
                    end
                    hi_run = 0;
                end else begin
                    hi_run++;
                end
                prev_ss0 = ss_n[0];
                if (seg >= 2 && busy === 1'b0) break;
                tick_cycle();
            end
            start = 1'b0;
            check("b2b segments",  64'(seg),     64'(2));
            check("b2b ss_n gap",  64'(gap_hi),  64'(SS_GAP_CYCLES + 1));
            check("b2b mosi bits", 64'(w),       64'(16'hA53C));
            check("b2b bit count", 64'(nb),      64'(16));
            check("b2b done",      64'(ndone),   64'(2));
            check("b2b rx_data",   64'(rx_data), 64'(32'h0000_003C));
            tick_cycle();
        end

        // ---- reset at the 5th sclk edge ----
        begin
            int   edges5, hit, n_stray;
            logic prev;
            slave     = 2'd0;
            cpol      = 1'b0;
            cpha      = 1'b0;
            lsb_first = 1'b0;
            len       = 6'd8;
            clk_div   = 8'd1;
            tx_data   = 32'h0000_00A5;
            loop_en   = 1'b1;
            start     = 1'b1;
            tick_cycle();
            start  = 1'b0;
            edges5 = 0;
            hit    = 0;
            prev   = sclk;
            for (int cyc = 1; cyc < 100; cyc++) begin
                if (sclk !== prev) edges5++;
                prev = sclk;
                if (edges5 == 5) begin
                    hit = 1;
                    break;
                end
                tick_cycle();
            end
            check("rst reached edge 5", 64'(hit), 64'(1));
            reset = 1'b1;
            tick_cycle();
            check("rst ss_n",    64'(ss_n),    64'(3'b111));
            check("rst sclk",    64'(sclk),    64'(0));
            check("rst busy",    64'(busy),    64'(0));
            check("rst done",    64'(done),    64'(0));
            check("rst rx_data", 64'(rx_data), 64'(0));
            check("rst mosi",    64'(mosi),    64'(0));
            reset   = 1'b0;
            n_stray = 0;
            for (int c = 0; c < 20; c++) begin
                tick_cycle();
                if (done === 1'b1 || busy !== 1'b0) n_stray++;
            end
            check("rst no later done", 64'(n_stray), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
